// File: rtl/toast_dmem.sv
// Data-memory responder: byte-enabled stores, registered loads, post-reset zero-fill, range check.
// Latency: read data registered, valid 1 cycle after the address; zero-fill takes DEPTH cycles.
// Backpressure: none, accepts every cycle; core must idle while init_busy_o is high. Mailbox: `DMEM_TOHOST_EN.
module toast_dmem #(
    parameter int          DEPTH          = 16384,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_2000,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [31:0] DMEM_addr_i,
    input  logic [3:0]  DMEM_wr_byte_en_i,
    input  logic [31:0] DMEM_wr_data_i,
    input  logic        DMEM_rst_i,
    output logic [31:0] DMEM_rd_data_o,
    input  logic        clear_req_i,
    output logic        init_busy_o,
    output logic        addr_err_o,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_data_o,
    output logic        test_pass_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_fill_we;

    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_rd_data;
    logic            r_addr_err;

    logic [31:0]     w_off;
    logic            w_in_range;
    logic [AW-1:0]   w_idx;
    logic            w_run;
    logic            w_wr_any;
    logic            w_arr_we;
    logic            w_tohost_hit;
    logic [31:0]     w_tohost_data;

    // Address decode: unsigned subtract makes addresses below BASE_ADDR wrap to huge offsets
    assign w_off      = DMEM_addr_i - BASE_ADDR;
    assign w_in_range = (w_off[31:2] < 30'(DEPTH));
    assign w_idx      = w_off[AW+1:2];
    assign w_run      = (r_state == S_RUN);
    assign w_wr_any   = |DMEM_wr_byte_en_i;
    assign w_arr_we   = w_run && w_in_range && !w_tohost_hit;

    // FSM state and fill-counter register
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= CLEAR_ON_RESET ? S_INIT : S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: fill walks every word once; a clear request restarts the walk from word 0
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fill_we   = 1'b0;
        case (r_state)
            S_INIT: begin
                w_fill_we = 1'b1;
                if (clear_req_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                if (clear_req_i) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    // Array write port: zero-fill owns the port during INIT, byte-lane stores during RUN
    always_ff @(posedge clk_i) begin
        if (w_fill_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_arr_we) begin
            for (int l = 0; l < 4; l++) begin
                if (DMEM_wr_byte_en_i[l]) begin
                    r_mem[w_idx][8*l +: 8] <= DMEM_wr_data_i[8*l +: 8];
                end
            end
        end
    end

    // Registered read: samples the array before this cycle's write lands (read-first)
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_rd_data <= '0;
        end else if (!w_run || DMEM_rst_i) begin
            r_rd_data <= '0;
        end else if (w_tohost_hit) begin
            r_rd_data <= w_tohost_data;
        end else if (w_in_range) begin
            r_rd_data <= r_mem[w_idx];
        end else begin
            r_rd_data <= '0;
        end
    end

    // Error pulse only for stores outside the array; speculative reads never flag
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_run && !w_in_range && w_wr_any && !w_tohost_hit;
        end
    end

`ifdef DMEM_TOHOST_EN
    logic        r_tohost_vld;
    logic [31:0] r_tohost_dat;

    assign w_tohost_hit  = (DMEM_addr_i[31:2] == TOHOST_ADDR[31:2]);
    assign w_tohost_data = r_tohost_dat;

    // Mailbox: merges stored lanes, valid is sticky until resetn_i
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_tohost_vld <= 1'b0;
            r_tohost_dat <= '0;
        end else if (w_run && w_tohost_hit && w_wr_any) begin
            r_tohost_vld <= 1'b1;
            for (int l = 0; l < 4; l++) begin
                if (DMEM_wr_byte_en_i[l]) begin
                    r_tohost_dat[8*l +: 8] <= DMEM_wr_data_i[8*l +: 8];
                end
            end
        end
    end

    assign tohost_valid_o = r_tohost_vld;
    assign tohost_data_o  = r_tohost_dat;
    assign test_pass_o    = r_tohost_vld && (r_tohost_dat == 32'd1);
`else
    assign w_tohost_hit   = 1'b0;
    assign w_tohost_data  = '0;
    assign tohost_valid_o = 1'b0;
    assign tohost_data_o  = '0;
    assign test_pass_o    = 1'b0;
`endif

    assign DMEM_rd_data_o = r_rd_data;
    assign addr_err_o     = r_addr_err;
    assign init_busy_o    = (r_state == S_INIT);

endmodule
